// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and issue-stage state for the 4-bit ALU slice.
package alu_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

  // Only ADD/SUB can raise a meaningful overflow.
  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic fwd_hit(input logic vld, input logic [ADDR_W-1:0] ex_rd,
                                   input logic [ADDR_W-1:0] rs);
    return vld && (ex_rd == rs) && (rs != '0);
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// NREG x W register file: two operand reads, one debug read, one write port
// where the EX writeback overrides a same-edge load. R0 is hardwired to zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int N  = NREG,
  parameter int W  = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  output logic [W-1:0]  dbg_data,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_addr,
  input  logic [W-1:0]  ex_data,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data
);
  logic [N-1:0][W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (ld_we) mem_d[ld_addr] = ld_data;
    if (ex_we) mem_d[ex_addr] = ex_data;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  assign rd1      = mem_q[rs1];
  assign rd2      = mem_q[rs2];
  assign dbg_data = mem_q[dbg_addr];
endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage feeding the combinational 4-bit ALU, with EX bypass
// and one-cycle writeback. ALU_ISSUE_OVFL_TRAP_EN enables the overflow trap.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] ALU_in1,
  output logic [DATA_W-1:0] ALU_in2,
  output logic [1:0]        opcode,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic              error,
  input  logic              flags_clr,
  output logic              zero_flag,
  output logic              ovfl_flag,
  output logic              trap,
  input  logic              trap_ack,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_e              state_q, state_d;
  logic                ex_valid_q, ex_valid_d;
  logic [ADDR_W-1:0]   ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0]   in1_q, in1_d, in2_q, in2_d;
  logic [1:0]          opcode_q, opcode_d;
  logic                zero_q, zero_d, ovfl_q, ovfl_d;
  logic [DATA_W-1:0]   rf_rd1, rf_rd2;
  logic                accept, wb_ovfl;

  assign in_ready = (state_q == RUN);
  assign accept   = in_valid & in_ready;
  assign wb_ovfl  = ex_valid_q & error & is_arith(opcode_q);

  alu_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .dbg_addr (dbg_addr),
    .rd1      (rf_rd1),
    .rd2      (rf_rd2),
    .dbg_data (dbg_data),
    .ex_we    (ex_valid_q),
    .ex_addr  (ex_rd_q),
    .ex_data  (ALU_out),
    .ld_we    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  always_comb begin
    ex_valid_d = accept;
    ex_rd_d    = ex_rd_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    opcode_d   = opcode_q;
    if (accept) begin
      ex_rd_d  = in_rd;
      opcode_d = in_op;
      in1_d    = fwd_hit(ex_valid_q, ex_rd_q, in_rs1) ? ALU_out : rf_rd1;
      in2_d    = fwd_hit(ex_valid_q, ex_rd_q, in_rs2) ? ALU_out : rf_rd2;
    end
    zero_d = ex_valid_q ? (ALU_out == '0) : zero_q;
    // A fresh overflow beats a same-edge clear.
    ovfl_d = (ovfl_q & ~flags_clr) | wb_ovfl;
  end

`ifdef ALU_ISSUE_OVFL_TRAP_EN
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (wb_ovfl)  state_d = TRAP;
      TRAP:    if (trap_ack) state_d = RUN;
      default: state_d = RUN;
    endcase
  end
  assign trap = (state_q == TRAP);
`else
  logic unused_trap_ack;
  assign unused_trap_ack = trap_ack;
  assign state_d = RUN;
  assign trap    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      opcode_q   <= '0;
      zero_q     <= 1'b0;
      ovfl_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      opcode_q   <= opcode_d;
      zero_q     <= zero_d;
      ovfl_q     <= ovfl_d;
    end
  end

  assign ALU_in1   = in1_q;
  assign ALU_in2   = in2_q;
  assign opcode    = opcode_q;
  assign zero_flag = zero_q;
  assign ovfl_flag = ovfl_q;
endmodule
